// File: rtl/sepet_kasa_if.sv
// Checkout bus: item stream, close/payment pulses and result outputs of sepet_kasa.
interface sepet_kasa_if #(
  parameter int TOPLAM_TL_W = 17
);
  logic                   urun_gecerli;
  logic                   urun_hazir;
  logic [19:0]            indirimli_fiyat;
  logic                   sepet_kapat;
  logic                   odeme_gecerli;
  logic [TOPLAM_TL_W-1:0] odeme_tl;
  logic [6:0]             odeme_kurus;
  logic [TOPLAM_TL_W-1:0] toplam_tl;
  logic [6:0]             toplam_kurus;
  logic [4:0]             urun_sayisi;
  logic [TOPLAM_TL_W-1:0] para_ustu_tl;
  logic [6:0]             para_ustu_kurus;
  logic                   sonuc_gecerli;
  logic                   yetersiz;
  logic                   hata;

  modport master (
    output urun_gecerli, indirimli_fiyat, sepet_kapat, odeme_gecerli, odeme_tl, odeme_kurus,
    input  urun_hazir, toplam_tl, toplam_kurus, urun_sayisi, para_ustu_tl, para_ustu_kurus,
           sonuc_gecerli, yetersiz, hata
  );

  modport slave (
    input  urun_gecerli, indirimli_fiyat, sepet_kapat, odeme_gecerli, odeme_tl, odeme_kurus,
    output urun_hazir, toplam_tl, toplam_kurus, urun_sayisi, para_ustu_tl, para_ustu_kurus,
           sonuc_gecerli, yetersiz, hata
  );
endinterface

// File: rtl/sepet_kasa.sv
// Checkout stage: accumulates discounted item prices in TL/kurus, takes payment, reports change.
//   state | meaning
//   BOS   | empty basket, ready for first item
//   TOPLA | collecting items
//   ODEME | basket closed, awaiting payment
//   SONUC | one-cycle result, change valid
module sepet_kasa #(
  parameter int MAKS_URUN   = 16,
  parameter int TOPLAM_TL_W = 17
) (
  input logic         clk,
  input logic         rst_n,
  sepet_kasa_if.slave bus
);
  localparam logic [1:0] BOS   = 2'd0;
  localparam logic [1:0] TOPLA = 2'd1;
  localparam logic [1:0] ODEME = 2'd2;
  localparam logic [1:0] SONUC = 2'd3;
  localparam logic [4:0] MAKS  = 5'(MAKS_URUN);

  logic [1:0]             state, state_nx;
  logic [TOPLAM_TL_W-1:0] tl_q, tl_nx, ch_tl_q, ch_tl_nx;
  logic [6:0]             k_q, k_nx, ch_k_q, ch_k_nx;
  logic [4:0]             cnt_q, cnt_nx;
  logic                   hazir_q, hazir_nx, sonuc_q, sonuc_nx;
  logic                   yet_q, yet_nx, hata_q, hata_nx;

  logic [12:0]            item_tl;
  logic [6:0]             item_k;
  logic [7:0]             k_sum, k_sum_m100;
  logic                   k_carry, odeme_az;

  assign item_tl    = bus.indirimli_fiyat[19:7];
  assign item_k     = bus.indirimli_fiyat[6:0];
  assign k_sum      = {1'b0, k_q} + {1'b0, item_k};
  assign k_sum_m100 = k_sum - 8'd100;
  assign k_carry    = (k_sum >= 8'd100);
  // kurus values are known legal here, so TL-then-kurus ordering equals the full-value compare
  assign odeme_az   = (bus.odeme_tl < tl_q) || ((bus.odeme_tl == tl_q) && (bus.odeme_kurus < k_q));

  always_comb begin
    state_nx = state;
    tl_nx    = tl_q;
    k_nx     = k_q;
    cnt_nx   = cnt_q;
    ch_tl_nx = ch_tl_q;
    ch_k_nx  = ch_k_q;
    hata_nx  = hata_q;
    sonuc_nx = 1'b0;
    yet_nx   = 1'b0;
    case (state)
      BOS, TOPLA: begin
        if (bus.urun_gecerli && hazir_q) begin
          if (item_k >= 7'd100) begin
            hata_nx = 1'b1;
          end else begin
            tl_nx  = tl_q + {{(TOPLAM_TL_W-13){1'b0}}, item_tl} + {{(TOPLAM_TL_W-1){1'b0}}, k_carry};
            k_nx   = k_carry ? k_sum_m100[6:0] : k_sum[6:0];
            cnt_nx = cnt_q + 5'd1;
            if (state == BOS) state_nx = TOPLA;
          end
        end
        if (state == TOPLA && bus.sepet_kapat) state_nx = ODEME;
      end
      ODEME: begin
        if (bus.odeme_gecerli) begin
          if (bus.odeme_kurus >= 7'd100) begin
            hata_nx = 1'b1;
          end else if (odeme_az) begin
            yet_nx = 1'b1;
          end else begin
            if (bus.odeme_kurus >= k_q) begin
              ch_k_nx  = bus.odeme_kurus - k_q;
              ch_tl_nx = bus.odeme_tl - tl_q;
            end else begin
              // modulo-128 wrap is harmless: the borrowed result is always below 100
              ch_k_nx  = bus.odeme_kurus + 7'd100 - k_q;
              ch_tl_nx = bus.odeme_tl - tl_q - {{(TOPLAM_TL_W-1){1'b0}}, 1'b1};
            end
            state_nx = SONUC;
            sonuc_nx = 1'b1;
          end
        end
      end
      default: begin
        state_nx = BOS;
        tl_nx    = '0;
        k_nx     = '0;
        cnt_nx   = '0;
      end
    endcase
    hazir_nx = (state_nx == BOS) || ((state_nx == TOPLA) && (cnt_nx < MAKS));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= BOS;
      tl_q    <= '0;
      k_q     <= '0;
      cnt_q   <= '0;
      ch_tl_q <= '0;
      ch_k_q  <= '0;
      hazir_q <= 1'b1;
      sonuc_q <= 1'b0;
      yet_q   <= 1'b0;
      hata_q  <= 1'b0;
    end else begin
      state   <= state_nx;
      tl_q    <= tl_nx;
      k_q     <= k_nx;
      cnt_q   <= cnt_nx;
      ch_tl_q <= ch_tl_nx;
      ch_k_q  <= ch_k_nx;
      hazir_q <= hazir_nx;
      sonuc_q <= sonuc_nx;
      yet_q   <= yet_nx;
      hata_q  <= hata_nx;
    end
  end

  assign bus.urun_hazir      = hazir_q;
  assign bus.toplam_tl       = tl_q;
  assign bus.toplam_kurus    = k_q;
  assign bus.urun_sayisi     = cnt_q;
  assign bus.para_ustu_tl    = ch_tl_q;
  assign bus.para_ustu_kurus = ch_k_q;
  assign bus.sonuc_gecerli   = sonuc_q;
  assign bus.yetersiz        = yet_q;
  assign bus.hata            = hata_q;
endmodule

// File: tb/tb_sepet_kasa.sv
// Bench for sepet_kasa: directed checkout scenarios then random baskets against a kurus-based model.
module tb_sepet_kasa;
  logic clk;
  logic rst_n;
  int   n_vec, n_fail;

  // model: money held as whole kurus, phase 0=empty 1=collecting 2=paying 3=result
  int m_tot, m_cnt, m_phase, m_ch, m_hata, m_yet;

  sepet_kasa_if #(.TOPLAM_TL_W(17)) bus ();
  sepet_kasa #(.MAKS_URUN(16), .TOPLAM_TL_W(17)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".toplam_tl"}, 32'(bus.toplam_tl), m_tot / 100);
    chk({tag, ".toplam_kurus"}, 32'(bus.toplam_kurus), m_tot % 100);
    chk({tag, ".urun_sayisi"}, 32'(bus.urun_sayisi), m_cnt);
    chk({tag, ".urun_hazir"}, 32'(bus.urun_hazir), 32'((m_phase == 0) || (m_phase == 1 && m_cnt < 16)));
    chk({tag, ".para_ustu_tl"}, 32'(bus.para_ustu_tl), m_ch / 100);
    chk({tag, ".para_ustu_kurus"}, 32'(bus.para_ustu_kurus), m_ch % 100);
    chk({tag, ".sonuc_gecerli"}, 32'(bus.sonuc_gecerli), 32'(m_phase == 3));
    chk({tag, ".yetersiz"}, 32'(bus.yetersiz), m_yet);
    chk({tag, ".hata"}, 32'(bus.hata), m_hata);
  endtask

  task automatic cycle(input string tag, input logic ug, input int itl, input int ik, input logic kap,
                       input logic og, input int otl, input int ok);
    int ph;
    bus.urun_gecerli    = ug;
    bus.indirimli_fiyat = {13'(itl), 7'(ik)};
    bus.sepet_kapat     = kap;
    bus.odeme_gecerli   = og;
    bus.odeme_tl        = 17'(otl);
    bus.odeme_kurus     = 7'(ok);
    ph    = m_phase;
    m_yet = 0;
    if (ph <= 1) begin
      if (ug && (ph == 0 || m_cnt < 16)) begin
        if (ik >= 100) m_hata = 1;
        else begin
          m_tot += itl * 100 + ik;
          m_cnt++;
          m_phase = 1;
        end
      end
      if (ph == 1 && kap) m_phase = 2;
    end else if (ph == 2) begin
      if (og) begin
        if (ok >= 100) m_hata = 1;
        else if (otl * 100 + ok < m_tot) m_yet = 1;
        else begin
          m_ch    = otl * 100 + ok - m_tot;
          m_phase = 3;
        end
      end
    end else begin
      m_phase = 0;
      m_tot   = 0;
      m_cnt   = 0;
    end
    tick();
    bus.urun_gecerli  = 1'b0;
    bus.sepet_kapat   = 1'b0;
    bus.odeme_gecerli = 1'b0;
    check_all(tag);
  endtask

  task automatic item(input int tl, input int k);
    cycle("item", 1'b1, tl, k, 1'b0, 1'b0, 0, 0);
  endtask
  task automatic kapat();
    cycle("kapat", 1'b0, 0, 0, 1'b1, 1'b0, 0, 0);
  endtask
  task automatic pay(input int tl, input int k);
    cycle("pay", 1'b0, 0, 0, 1'b0, 1'b1, tl, k);
  endtask
  task automatic idle();
    cycle("idle", 1'b0, 0, 0, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.urun_gecerli    = 1'b1;
    bus.indirimli_fiyat = {13'd3, 7'd3};
    bus.sepet_kapat     = 1'b1;
    bus.odeme_gecerli   = 1'b1;
    tick();
    rst_n = 1'b1;
    bus.urun_gecerli  = 1'b0;
    bus.sepet_kapat   = 1'b0;
    bus.odeme_gecerli = 1'b0;
    m_tot = 0; m_cnt = 0; m_phase = 0; m_ch = 0; m_hata = 0; m_yet = 0;
    check_all("reset");
  endtask

  initial begin
    n_vec = 0;
    n_fail = 0;
    rst_n = 1'b0;
    bus.urun_gecerli = 1'b0;
    bus.indirimli_fiyat = '0;
    bus.sepet_kapat = 1'b0;
    bus.odeme_gecerli = 1'b0;
    bus.odeme_tl = '0;
    bus.odeme_kurus = '0;
    tick();
    do_reset();

    // 12.50 + 7.75 = 20.25 with kurus carry, paid with 50.00
    item(12, 50);
    item(7, 75);
    chk("carry.tl", 32'(bus.toplam_tl), 32'd20);
    chk("carry.kurus", 32'(bus.toplam_kurus), 32'd25);
    chk("carry.count", 32'(bus.urun_sayisi), 32'd2);
    kapat();
    pay(50, 0);
    chk("change.tl", 32'(bus.para_ustu_tl), 32'd29);
    chk("change.kurus", 32'(bus.para_ustu_kurus), 32'd75);
    chk("change.sonuc", 32'(bus.sonuc_gecerli), 32'd1);
    idle();
    chk("after.sonuc", 32'(bus.sonuc_gecerli), 32'd0);
    chk("after.hazir", 32'(bus.urun_hazir), 32'd1);

    // short payment then exact payment
    item(12, 50);
    item(7, 75);
    kapat();
    pay(20, 0);
    chk("short.yetersiz", 32'(bus.yetersiz), 32'd1);
    idle();
    pay(20, 25);
    chk("exact.change", 32'({bus.para_ustu_tl, bus.para_ustu_kurus}), 32'd0);
    idle();

    // full basket of 16 x 5000.99, 17th ignored
    for (int i = 0; i < 16; i++) item(5000, 99);
    item(5000, 99);
    chk("full.tl", 32'(bus.toplam_tl), 32'd80015);
    chk("full.kurus", 32'(bus.toplam_kurus), 32'd84);
    chk("full.hazir", 32'(bus.urun_hazir), 32'd0);
    kapat();
    pay(90000, 0);
    idle();

    // close in the same cycle as the last item; illegal kurus on item and payment
    item(30, 120);
    chk("bad_item.hata", 32'(bus.hata), 32'd1);
    item(10, 0);
    cycle("kapat_with_item", 1'b1, 5, 50, 1'b1, 1'b0, 0, 0);
    chk("kapat_with_item.kurus", 32'(bus.toplam_kurus), 32'd50);
    pay(30, 100);
    pay(30, 0);
    chk("late_pay.change", 32'(bus.para_ustu_tl), 32'd14);
    idle();

    // close in empty basket is ignored; reset while awaiting payment
    kapat();
    pay(1, 0);
    item(10, 0);
    kapat();
    do_reset();

    // random baskets
    for (int b = 0; b < 40; b++) begin
      int n, tries, p;
      if ($urandom_range(0, 14) == 0) do_reset();
      n = $urandom_range(1, 18);
      for (int i = 0; i < n; i++) begin
        int k, tl;
        tl = $urandom_range(0, 5000);
        k  = ($urandom_range(0, 19) == 0) ? $urandom_range(100, 127) : $urandom_range(0, 99);
        if ($urandom_range(0, 7) == 0)
          cycle("noise", 1'b0, 0, 0, 1'b0, 1'b1, $urandom_range(0, 100), $urandom_range(0, 99));
        cycle("rnd_item", 1'b1, tl, k, (i == n - 1) && ($urandom_range(0, 1) == 1), 1'b0, 0, 0);
      end
      if (m_phase == 1) kapat();
      tries = 0;
      while (m_phase == 2 && tries < 4) begin
        p = m_tot + $urandom_range(0, 2000) - 1000;
        if (p < 0) p = 0;
        if ($urandom_range(0, 9) == 0) pay(p / 100, $urandom_range(100, 127));
        else pay(p / 100, p % 100);
        tries++;
      end
      if (m_phase == 2) pay(m_tot / 100, m_tot % 100);
      idle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule

// File: doc/sepet_kasa.md
Name: sepet_kasa

Overview:
Checkout register stage directly downstream of the discount calculator. It accepts discounted item prices in the packed {TL[12:0], kurus[6:0]} format, accumulates the basket total with kurus-to-TL carry, and on basket close accepts a payment. It then reports change or an insufficient-payment flag. One basket is processed at a time.

Parameters:
MAKS_URUN, 16, maximum items per basket
TOPLAM_TL_W, 17, width of TL totals; must hold MAKS_URUN*5000 (80000 fits in 17 bits)

Ports:
clk  in  1  clock, rising-edge
rst_n  in  1  synchronous, active-low reset
urun_gecerli  in  1  item price valid
urun_hazir  out  1  block ready to accept an item
indirimli_fiyat  in  20  item price: [19:7] = TL, [6:0] = kurus (legal 0..99)
sepet_kapat  in  1  close basket, single-cycle pulse
odeme_gecerli  in  1  payment valid, single-cycle pulse
odeme_tl  in  TOPLAM_TL_W  payment TL
odeme_kurus  in  7  payment kurus (legal 0..99)
toplam_tl  out  TOPLAM_TL_W  running basket total, TL part
toplam_kurus  out  7  running basket total, kurus part (always 0..99)
urun_sayisi  out  5  accepted item count
para_ustu_tl  out  TOPLAM_TL_W  change, TL part
para_ustu_kurus  out  7  change, kurus part
sonuc_gecerli  out  1  change valid, one-cycle pulse
yetersiz  out  1  payment insufficient, one-cycle pulse
hata  out  1  sticky flag: illegal kurus value was received

Behaviour:
- Reset: rst_n=0 at a clk edge overrides all other inputs in every state.
  - State goes to BOS.
  - Every output register clears to 0, except urun_hazir, which goes to 1.
  - Reset during TOPLA or ODEME discards the basket.
- States: BOS (empty), TOPLA (collecting), ODEME (awaiting payment), SONUC (result).
- urun_hazir = 1 in BOS, and in TOPLA while urun_sayisi < MAKS_URUN. It is 0 otherwise.
- Item accept: an item is accepted on urun_gecerli & urun_hazir.
  - BOS → TOPLA on the first accepted item.
  - The item with kurus ≥ 100 is dropped: no count, no add. It sets hata.
- Add arithmetic, per accepted item:
  - s = toplam_kurus + item_kurus.
  - If s ≥ 100: toplam_kurus = s − 100 and toplam_tl += item_TL + 1.
  - Else: toplam_kurus = s and toplam_tl += item_TL.
  - urun_sayisi increments.
  - The updated total and count are visible on the next cycle (latency 1).
- Full basket: when urun_sayisi = MAKS_URUN, urun_hazir = 0 and further items are ignored. The total does not saturate, because TOPLAM_TL_W is sized for the worst case.
- Close:
  - sepet_kapat in TOPLA → ODEME.
  - sepet_kapat in BOS, ODEME or SONUC is ignored.
  - If an item is accepted in the same cycle as sepet_kapat, the item is included in the total before ODEME.
  - urun_hazir = 0 in ODEME and SONUC.
- Payment in ODEME, on odeme_gecerli:
  - odeme_kurus ≥ 100: payment ignored, hata set, stay in ODEME.
  - Otherwise compare P = odeme_tl*100 + odeme_kurus with T = toplam_tl*100 + toplam_kurus.
  - P < T: yetersiz = 1 for exactly the next cycle, stay in ODEME, change outputs unchanged.
  - P ≥ T: change is computed with borrow, then → SONUC.
    - If odeme_kurus ≥ toplam_kurus: para_ustu_kurus = odeme_kurus − toplam_kurus and para_ustu_tl = odeme_tl − toplam_tl.
    - Else: para_ustu_kurus = odeme_kurus + 100 − toplam_kurus and para_ustu_tl = odeme_tl − toplam_tl − 1.
  - odeme_gecerli outside ODEME is ignored.
- SONUC lasts exactly one cycle, then → BOS.
  - sonuc_gecerli = 1 exactly while in SONUC.
  - On SONUC → BOS, toplam_tl, toplam_kurus and urun_sayisi clear to 0.
  - para_ustu_* hold their value until the next successful payment or reset.
  - An item presented during SONUC is not accepted (urun_hazir = 0).
- hata is sticky; only reset clears it.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Reset; items 12.50 ({13'd12,7'd50}) then 7.75 → after the second accept: toplam 20.25, urun_sayisi 2 (carry path exercised).
- With that basket: sepet_kapat, then pay 50.00 → para_ustu 29.75 and sonuc_gecerli high for exactly one cycle; next cycle state BOS, toplam 0.00, urun_sayisi 0, urun_hazir 1.
- Basket 20.25, pay 20.00 → yetersiz pulses one cycle, state stays ODEME; then pay 20.25 → para_ustu 0.00, sonuc_gecerli pulses.
- 16 items of 5000.99 → toplam_tl 80015, toplam_kurus 84, urun_hazir 0; a 17th item is ignored; sepet_kapat accepted in the same cycle as item 16 → total includes item 16.
- Item with kurus 120 → dropped, hata=1, urun_sayisi unchanged; in ODEME pay 30.100 → ignored; hata stays 1; a later legal payment completes normally.
- sepet_kapat in BOS → no state change; rst_n=0 for one cycle while in ODEME with total 10.00 → next cycle all outputs 0, urun_hazir 1, state BOS.
